// File: rtl/skew_column_feeder_if.sv
// skew_column_feeder_if
//   Bundles the column-feeder handshake and data buses.
//   master : the side that loads columns, starts tiles and applies stall
//            (drives wr_valid, wr_data, start, len, stall).
//   slave  : the feeder itself (drives wr_ready, out, out_enable, busy,
//            done, count).
//   Lane i of wr_data/out sits at bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
interface skew_column_feeder_if #(
  parameter int HEIGHT     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int W  = DATA_WIDTH * HEIGHT;
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          start;
  logic [CW-1:0] len;
  logic          stall;
  logic [W-1:0]  out;
  logic          out_enable;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output wr_valid, wr_data, start, len, stall,
    input  wr_ready, out, out_enable, busy, done, count
  );

  modport slave (
    input  wr_valid, wr_data, start, len, stall,
    output wr_ready, out, out_enable, busy, done, count
  );
endinterface

// File: rtl/skew_column_feeder.sv
// skew_column_feeder
//   Buffers a matrix tile column by column, then replays it one HEIGHT-lane
//   column per cycle into the input skew shifter array. After the last
//   column, HEIGHT-1 zero columns are driven so the deepest skew lane
//   drains. A stall input freezes the stream without losing columns.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : skew_column_feeder_if.slave (write side, start/len, stall,
//          out/out_enable, busy/done, count)
//
// Build option
//   SKEW_FEEDER_FLUSH_EN : when defined, the FLUSH state emits HEIGHT-1
//   zero columns after the tile. When undefined, STREAM goes straight to
//   DONE and the skew array has to be drained externally.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accepting column writes, waiting for start
// STREAM | replaying buffered column rd_ptr, advancing when not stalled
// FLUSH  | driving zero columns until the deepest skew lane has drained
// DONE   | one-cycle completion pulse, buffer emptied
module skew_column_feeder #(
  parameter int HEIGHT     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input logic               clk,
  input logic               rst,
  skew_column_feeder_if.slave bus
);
  localparam int W  = DATA_WIDTH * HEIGHT;
  localparam int CW = $clog2(DEPTH + 1);
  // Buffer address width; one bit minimum so DEPTH=1 still has an index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int FW = (HEIGHT > 2) ? $clog2(HEIGHT - 1) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] len_q;
  logic [W-1:0]  buf_q [2**AW];
`ifdef SKEW_FEEDER_FLUSH_EN
  logic [FW-1:0] flush_q;
`endif

  logic          wr_ready_d;
  logic [W-1:0]  out_d;
  logic          out_enable_d;
  logic [CW-1:0] eff_len_d;

  // Requested length clamped to what is actually buffered.
  assign eff_len_d = (bus.len < count_q) ? bus.len : count_q;

  always_comb begin
    wr_ready_d   = !rst && (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && !bus.start;
    out_d        = '0;
    out_enable_d = 1'b0;
    case (state_q)
      S_STREAM: begin
        out_d        = buf_q[rd_ptr_q];
        out_enable_d = !bus.stall;
      end
      S_FLUSH: begin
        out_enable_d = !bus.stall;
      end
      default: begin
        out_d        = '0;
        out_enable_d = 1'b0;
      end
    endcase
  end

  assign bus.wr_ready   = wr_ready_d;
  assign bus.out        = out_d;
  assign bus.out_enable = out_enable_d;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.count      = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
`ifdef SKEW_FEEDER_FLUSH_EN
      flush_q  <= '0;
`endif
    end else begin
      // wr_ready already restricts writes to IDLE with room and no start.
      if (bus.wr_valid && wr_ready_d) begin
        buf_q[count_q[AW-1:0]] <= bus.wr_data;
        count_q                <= count_q + CW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            len_q    <= eff_len_d;
            rd_ptr_q <= '0;
            state_q  <= (eff_len_d == '0) ? S_DONE : S_STREAM;
          end
        end

        S_STREAM: begin
          if (!bus.stall) begin
            if (CW'(rd_ptr_q) == len_q - CW'(1)) begin
              rd_ptr_q <= '0;
`ifdef SKEW_FEEDER_FLUSH_EN
              // Down-counter: terminal count 0 marks the last zero column.
              flush_q  <= FW'(HEIGHT - 2);
              state_q  <= S_FLUSH;
`else
              state_q  <= S_DONE;
`endif
            end else begin
              rd_ptr_q <= rd_ptr_q + AW'(1);
            end
          end
        end

`ifdef SKEW_FEEDER_FLUSH_EN
        S_FLUSH: begin
          if (!bus.stall) begin
            if (flush_q == '0) begin
              state_q <= S_DONE;
            end else begin
              flush_q <= flush_q - FW'(1);
            end
          end
        end
`endif

        S_DONE: begin
          // Any columns beyond the streamed length are dropped here.
          count_q <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_skew_column_feeder.sv
module tb_skew_column_feeder;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int W  = H * DW;
  localparam int CW = $clog2(D + 1);
`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int FL = H - 1;
`else
  localparam int FL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  skew_column_feeder_if #(.HEIGHT(H), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

  skew_column_feeder #(.HEIGHT(H), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int n_wr;
    int len;
    int s1;
    int s2;
    int exp_l;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] col_data(input int c);
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < H; i++) d[DW*i +: DW] = DW'(16 * c + i);
    return d;
  endfunction

  // Scoreboard: every enabled output column must match the oldest expected.
  always @(negedge clk) begin
    if (bus.out_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got column %0h expected none at %0t", bus.out, $time);
      end else begin
        chk("out_col", 32'(bus.out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_out_enable", 32'(bus.out_enable), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic write_col(input logic [W-1:0] d, input bit accept);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    @(negedge clk);
    chk("wr_ready", 32'(bus.wr_ready), 32'(accept));
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic run_stream(input int len_v, input int l_v, input int s1, input int s2,
                            input int exp_done, input bit with_wr, input int cnt_before);
    int done_k;
    for (int c = 0; c < l_v; c++) exp_q.push_back(col_data(c));
    if (l_v > 0) for (int z = 0; z < FL; z++) exp_q.push_back('0);
    bus.start = 1'b1;
    bus.len   = CW'(len_v);
    if (with_wr) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hDEADBEEF;
    end
    @(negedge clk);
    if (with_wr) chk("wr_ready_with_start", 32'(bus.wr_ready), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
    done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      bus.stall = (k == s1) || (k == s2);
      @(negedge clk);
      if (k == 1) begin
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("count_during", 32'(bus.count), 32'(cnt_before));
      end
      if (bus.done === 1'b1) begin
        done_k = k;
        chk("out_enable_in_done", 32'(bus.out_enable), 32'd0);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
      end
      @(posedge clk); #1;
      if (done_k >= 0) break;
    end
    bus.stall = 1'b0;
    chk("done_cycle", 32'(done_k), 32'(exp_done));
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);
    chk("idle_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("columns_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.stall    = 1'b0;

    //          n_wr len s1  s2          exp_l exp_done
    vecs[0] = '{4,   4,  -1, -1,         4,    4 + FL + 1};
    vecs[1] = '{4,   4,   2,  6,         4,    (FL > 0) ? 10 : 6};
    vecs[2] = '{8,   15, -1, -1,         8,    8 + FL + 1};
    vecs[3] = '{0,   3,  -1, -1,         0,    1};
    vecs[4] = '{2,   2,  -1, -1,         2,    2 + FL + 1};
    vecs[5] = '{6,   3,  -1, -1,         3,    3 + FL + 1};
    vecs[6] = '{3,   0,  -1, -1,         0,    1};

    for (int r = 0; r < 7; r++) begin
      do_reset();
      for (int c = 0; c < vecs[r].n_wr; c++) write_col(col_data(c), 1'b1);
      chk("count_loaded", 32'(bus.count), 32'(vecs[r].n_wr));
      if (vecs[r].n_wr == D) begin
        write_col(32'hFFFFFFFF, 1'b0);
        chk("count_full", 32'(bus.count), 32'(D));
      end
      run_stream(vecs[r].len, vecs[r].exp_l, vecs[r].s1, vecs[r].s2,
                 vecs[r].exp_done, 1'b0, vecs[r].n_wr);
    end

    // start and wr_valid together: write refused, count unchanged
    do_reset();
    for (int c = 0; c < 2; c++) write_col(col_data(c), 1'b1);
    run_stream(2, 2, -1, -1, 2 + FL + 1, 1'b1, 2);

    // reset in cycle t+3 of a 4-column stream aborts without done
    do_reset();
    for (int c = 0; c < 4; c++) write_col(col_data(c), 1'b1);
    for (int c = 0; c < 4; c++) exp_q.push_back(col_data(c));
    bus.start = 1'b1;
    bus.len   = CW'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("abort_no_done_early", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_ready_in_rst", 32'(bus.wr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_out_enable", 32'(bus.out_enable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("abort_cols_seen", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
